// File: rtl/gate_sweep_checker.sv
// Exhaustive (a,b) sweep driver and checker for the combinational gate library.
// Optional macro GATE_CHK_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module gate_sweep_checker #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic [WIDTH-1:0]     dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [2*WIDTH-1:0]   first_err_vec,
  output logic                 first_err_valid
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [CNT_W-1:0]     r_cnt;
  logic [ERR_W-1:0]     r_err;
  logic                 r_pass;
  logic [2*WIDTH-1:0]   r_fvec;
  logic                 r_fvalid;

  logic [2*WIDTH-1:0]   w_vec;
  logic [2*WIDTH-1:0]   w_vec_next;
  logic [WIDTH-1:0]     w_exp;
  logic                 w_mis;
  logic                 w_last;
  logic                 w_finish;
  logic [ERR_W-1:0]     w_err_next;

  function automatic logic [WIDTH-1:0] f_expected(input logic [2:0] sel,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    case (sel)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = ~a;
      3'd3:    y = a ^ b;
      3'd4:    y = ~(a & b);
      3'd5:    y = ~(a | b);
      3'd6:    y = ~(a ^ b);
      default: y = '0;
    endcase
    return y;
  endfunction

  // The driven operands double as the sweep index, so no separate vector register.
  assign w_vec      = {r_a, r_b};
  assign w_vec_next = w_vec + (2*WIDTH)'(1);
  assign w_last     = &w_vec;
  assign w_exp      = f_expected(r_op, r_a, r_b);
  assign w_mis      = (dut_y != w_exp);
  assign w_err_next = (w_mis && !(&r_err)) ? r_err + ERR_W'(1) : r_err;
`ifdef GATE_CHK_STOP_ON_ERR_EN
  assign w_finish   = w_last || w_mis;
`else
  assign w_finish   = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: begin
        busy = 1'b1;
        if (r_cnt == CNT_LAST) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy   = 1'b1;
        w_next = w_finish ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // pass is settled on entry to DONE so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_err    <= '0;
      r_pass   <= 1'b0;
      r_fvec   <= '0;
      r_fvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op     <= op;
          r_a      <= '0;
          r_b      <= '0;
          r_cnt    <= '0;
          r_err    <= '0;
          r_pass   <= 1'b0;
          r_fvec   <= '0;
          r_fvalid <= 1'b0;
        end
        S_SETTLE: r_cnt <= r_cnt + CNT_W'(1);
        S_SAMPLE: begin
          r_err <= w_err_next;
          if (w_mis && !r_fvalid) begin
            r_fvec   <= w_vec;
            r_fvalid <= 1'b1;
          end
          if (w_finish) begin
            r_pass <= (w_err_next == '0);
          end else begin
            r_a   <= w_vec_next[2*WIDTH-1:WIDTH];
            r_b   <= w_vec_next[WIDTH-1:0];
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_a           = r_a;
  assign dut_b           = r_b;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_err_vec   = r_fvec;
  assign first_err_valid = r_fvalid;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: a fault-injectable gate model feeds dut_y,
// a sweep-level reference model predicts each sweep's result.
module tb_gate_sweep_checker;
  localparam int W   = 2;
  localparam int S   = 2;
  localparam int EW  = 4;
  localparam int NV  = 1 << (2*W);
  localparam int SAT = (1 << EW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [2:0]     op;
  logic [W-1:0]   dut_a, dut_b, dut_y;
  logic           busy, done, pass;
  logic [EW-1:0]  err_count;
  logic [2*W-1:0] first_err_vec;
  logic           first_err_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit stop_en;

  int           gate_op = 0;
  logic         stuck0  = 1'b0;
  logic [W-1:0] flip_tbl [NV];

  typedef struct {
    logic [EW-1:0]  err;
    logic           pass;
    logic [2*W-1:0] fvec;
    logic           fvalid;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int             dcyc;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  exp_t mon_e;

  gate_sweep_checker #(.WIDTH(W), .SETTLE(S), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] ref_gate(input int o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (o)
      0: return a & b;
      1: return a | b;
      2: return ~a;
      3: return a ^ b;
      4: return ~(a & b);
      5: return ~(a | b);
      6: return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  // Gate under test: a library gate with optional stuck-at-0 or per-vector bit flips.
  assign dut_y = stuck0 ? '0 : (ref_gate(gate_op, dut_a, dut_b) ^ flip_tbl[{dut_a, dut_b}]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Whole-sweep prediction: walk all vectors, count mismatches, note the first.
  function automatic exp_t model(input int o, input int start_cyc);
    exp_t e;
    int cnt = 0;
    int first = -1;
    int last_v = 0;
    for (int v = 0; v < NV; v++) begin
      if (!(stop_en && cnt > 0)) begin
        logic [W-1:0] a, b, y;
        a = W'(v >> W);
        b = W'(v);
        y = stuck0 ? '0 : (ref_gate(gate_op, a, b) ^ flip_tbl[v]);
        last_v = v;
        if (y != ref_gate(o, a, b)) begin
          cnt++;
          if (first < 0) first = v;
        end
      end
    end
    e.err    = EW'((cnt > SAT) ? SAT : cnt);
    e.pass   = (cnt == 0);
    e.fvalid = (first >= 0);
    e.fvec   = (first >= 0) ? (2*W)'(first) : '0;
    e.a      = W'(last_v >> W);
    e.b      = W'(last_v);
    e.dcyc   = start_cyc + 1 + (last_v + 1) * (S + 1);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got 1 want 0 (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        chk("done_cycle", cyc, mon_e.dcyc);
        chk("err_count", err_count, mon_e.err);
        chk("pass", pass, mon_e.pass);
        chk("first_err_valid", first_err_valid, mon_e.fvalid);
        chk("first_err_vec", first_err_vec, mon_e.fvec);
        chk("final_a", dut_a, mon_e.a);
        chk("final_b", dut_b, mon_e.b);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  task automatic load_fault(input int gop, input int fault);
    gate_op = gop;
    stuck0  = (fault == 1);
    for (int v = 0; v < NV; v++) begin
      if (fault == 2)      flip_tbl[v] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, (1 << W) - 1)) : '0;
      else if (fault == 3) flip_tbl[v] = '1;
      else                 flip_tbl[v] = '0;
    end
  endtask

  task automatic sweep(input int o, input int gop, input int fault, input bit perturb);
    exp_t e;
    load_fault(gop, fault);
    @(posedge clk); #1;
    e = model(o, cyc);
    q.push_back(e);
    last_exp = e;
    op = 3'(o);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (perturb) begin
      repeat (4) @(posedge clk);
      #1 op = 3'($urandom);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int t = 0; t < NV * (S + 1) + 20 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("sweep_completed", q.size(), 0);
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_pass", pass, last_exp.pass);
    chk("hold_err_count", err_count, last_exp.err);
    chk("hold_first_err_vec", first_err_vec, last_exp.fvec);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
`ifdef GATE_CHK_STOP_ON_ERR_EN
    stop_en = 1'b1;
`else
    stop_en = 1'b0;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    load_fault(0, 0);
    #12;
    chk("rst_dut_a", dut_a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_err", {first_err_valid, first_err_vec}, 0);
    @(negedge clk) rst_n = 1'b1;

    sweep(0, 0, 0, 0);   // correct AND
    sweep(6, 3, 0, 0);   // XNOR slot fed by XOR: every vector fails, count saturates
    sweep(2, 2, 1, 0);   // NOT stuck at 0
    sweep(3, 3, 0, 1);   // op and start disturbed mid-sweep
    sweep(7, 7, 0, 0);   // reserved op expects zero
    sweep(1, 1, 1, 0);   // OR stuck at 0

    // Abandon a sweep with reset mid-flight; no result is queued so any done is flagged.
    load_fault(4, stop_en ? 0 : 3);
    @(posedge clk); #1;
    op = 3'd4;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_dut_ab", {dut_a, dut_b}, 0);
    chk("arst_busy_done", {busy, done}, 0);
    chk("arst_pass", pass, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_first_err", {first_err_valid, first_err_vec}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    sweep(4, 4, 0, 0);

    for (int i = 0; i < 8; i++) begin
      int o, f, g;
      o = $urandom_range(0, 7);
      f = $urandom_range(0, 3);
      g = (f == 0 && $urandom_range(0, 1) == 0) ? o : $urandom_range(0, 7);
      sweep(o, g, f, (f == 0 && g == o));
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
